// File: rtl/mask_encoder_seq_if.sv
// rtl/mask_encoder_seq_if.sv - bitmask-in / index-out handshake bundle for mask_encoder_seq
interface mask_encoder_seq_if #(
  parameter int N = 4
) ();
  localparam int W = $clog2(N);

  logic [N-1:0] in_vec;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] out_idx;
  logic         out_valid;
  logic         out_ready;
  logic         out_last;
  logic         busy;
  logic         err_zero;
  logic         err_multi;

  modport master (
    output in_vec, in_valid, out_ready,
    input  in_ready, out_idx, out_valid, out_last, busy, err_zero, err_multi
  );

  modport slave (
    input  in_vec, in_valid, out_ready,
    output in_ready, out_idx, out_valid, out_last, busy, err_zero, err_multi
  );
endinterface

// File: rtl/mask_encoder_seq.sv
// rtl/mask_encoder_seq.sv - sequential bitmask-to-index encoder, lowest set bit first
// Optional strict one-hot mode (reject multi-hot masks) enabled by defining ENC_ONEHOT_STRICT_EN.
module mask_encoder_seq #(
  parameter int N = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  mask_encoder_seq_if.slave bus
);
  localparam int W = $clog2(N);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_EMIT = 1'b1;

  logic [0:0]   state_q, state_d;
  logic [N-1:0] pend_q, pend_d, pend_nxt;
  logic [W-1:0] idx_q, idx_d;
  logic         valid_q, valid_d;
  logic         last_q, last_d;
  logic         in_ready_q, in_ready_d;
  logic         busy_q, busy_d;
  logic         err_zero_q, err_zero_d;
  logic         err_multi_q, err_multi_d;

  function automatic logic [W-1:0] lowest(input logic [N-1:0] v);
    logic [W-1:0] r;
    r = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (v[i]) r = W'(i);
    end
    return r;
  endfunction

  function automatic logic is_single(input logic [N-1:0] v);
    return (v != '0) && ((v & (v - N'(1))) == '0);
  endfunction

  always_comb begin
    state_d     = state_q;
    pend_d      = pend_q;
    idx_d       = idx_q;
    valid_d     = valid_q;
    last_d      = last_q;
    in_ready_d  = in_ready_q;
    busy_d      = busy_q;
    err_zero_d  = 1'b0;
    err_multi_d = 1'b0;
    pend_nxt    = pend_q & ~(N'(1) << idx_q);

    case (state_q)
      S_IDLE: begin
        in_ready_d = 1'b1;
        busy_d     = 1'b0;
        valid_d    = 1'b0;
        last_d     = 1'b0;
        if (bus.in_valid && in_ready_q) begin
          if (bus.in_vec == '0) begin
            err_zero_d = 1'b1;
`ifdef ENC_ONEHOT_STRICT_EN
          end else if (!is_single(bus.in_vec)) begin
            err_multi_d = 1'b1;
`endif
          end else begin
            pend_d     = bus.in_vec;
            state_d    = S_EMIT;
            idx_d      = lowest(bus.in_vec);
            last_d     = is_single(bus.in_vec);
            valid_d    = 1'b1;
            in_ready_d = 1'b0;
            busy_d     = 1'b1;
          end
        end
      end
      default: begin
        // Pending bits are retired only on a completed output handshake.
        if (valid_q && bus.out_ready) begin
          pend_d = pend_nxt;
          if (last_q) begin
            state_d    = S_IDLE;
            valid_d    = 1'b0;
            last_d     = 1'b0;
            busy_d     = 1'b0;
            in_ready_d = 1'b1;
          end else begin
            idx_d  = lowest(pend_nxt);
            last_d = is_single(pend_nxt);
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      pend_q      <= '0;
      idx_q       <= '0;
      valid_q     <= 1'b0;
      last_q      <= 1'b0;
      in_ready_q  <= 1'b0;
      busy_q      <= 1'b0;
      err_zero_q  <= 1'b0;
      err_multi_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pend_q      <= pend_d;
      idx_q       <= idx_d;
      valid_q     <= valid_d;
      last_q      <= last_d;
      in_ready_q  <= in_ready_d;
      busy_q      <= busy_d;
      err_zero_q  <= err_zero_d;
      err_multi_q <= err_multi_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_idx   = idx_q;
  assign bus.out_valid = valid_q;
  assign bus.out_last  = last_q;
  assign bus.busy      = busy_q;
  assign bus.err_zero  = err_zero_q;
  assign bus.err_multi = err_multi_q;
endmodule

// File: tb/tb_mask_encoder_seq.sv
// tb/tb_mask_encoder_seq.sv - directed self-checking bench for mask_encoder_seq
module tb_mask_encoder_seq;
  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  mask_encoder_seq_if #(.N(4)) bus_if ();

  mask_encoder_seq #(.N(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus_if.in_vec = 4'b0000;
    bus_if.in_valid = 1'b0;
    bus_if.out_ready = 1'b0;
    for (int c = 0; c < 2; c++) begin
      tick();
      n_checks++; if (bus_if.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", bus_if.out_valid); end
      n_checks++; if (bus_if.in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 0", bus_if.in_ready); end
      n_checks++; if ({bus_if.busy, bus_if.out_last, bus_if.err_zero, bus_if.err_multi} !== 4'b0000) begin
        n_fail++; $display("FAIL reset_flags: got %b expected 0000", {bus_if.busy, bus_if.out_last, bus_if.err_zero, bus_if.err_multi});
      end
      n_checks++; if (bus_if.out_idx !== 2'd0) begin n_fail++; $display("FAIL reset_out_idx: got %0d expected 0", bus_if.out_idx); end
    end
    rst_n = 1'b1;
    tick();
    n_checks++; if (bus_if.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_release_in_ready: got %b expected 1", bus_if.in_ready); end
  endtask

  task automatic test_onehot();
    bus_if.in_vec = 4'b0100;
    bus_if.in_valid = 1'b1;
    bus_if.out_ready = 1'b1;
    tick();
    bus_if.in_valid = 1'b0;
    n_checks++; if ({bus_if.out_valid, bus_if.out_last, bus_if.busy, bus_if.in_ready} !== 4'b1110) begin
      n_fail++; $display("FAIL onehot_flags: got %b expected 1110", {bus_if.out_valid, bus_if.out_last, bus_if.busy, bus_if.in_ready});
    end
    n_checks++; if (bus_if.out_idx !== 2'd2) begin n_fail++; $display("FAIL onehot_idx: got %0d expected 2", bus_if.out_idx); end
    tick();
    n_checks++; if ({bus_if.out_valid, bus_if.busy, bus_if.in_ready} !== 3'b001) begin
      n_fail++; $display("FAIL onehot_done: got %b expected 001", {bus_if.out_valid, bus_if.busy, bus_if.in_ready});
    end
  endtask

  task automatic test_multi_stream();
    logic [1:0] exp_idx [3];
    logic       exp_last [3];
    exp_idx = '{2'd0, 2'd1, 2'd3};
    exp_last = '{1'b0, 1'b0, 1'b1};
    bus_if.in_vec = 4'b1011;
    bus_if.in_valid = 1'b1;
    bus_if.out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      bus_if.in_valid = 1'b0;
      n_checks++; if (bus_if.out_valid !== 1'b1 || bus_if.out_idx !== exp_idx[k]) begin
        n_fail++; $display("FAIL multi_idx[%0d]: got valid=%b idx=%0d expected valid=1 idx=%0d", k, bus_if.out_valid, bus_if.out_idx, exp_idx[k]);
      end
      n_checks++; if (bus_if.out_last !== exp_last[k] || bus_if.in_ready !== 1'b0) begin
        n_fail++; $display("FAIL multi_last[%0d]: got last=%b in_ready=%b expected last=%b in_ready=0", k, bus_if.out_last, bus_if.in_ready, exp_last[k]);
      end
    end
    tick();
    n_checks++; if ({bus_if.out_valid, bus_if.in_ready} !== 2'b01) begin
      n_fail++; $display("FAIL multi_done: got %b expected 01", {bus_if.out_valid, bus_if.in_ready});
    end
  endtask

  task automatic test_backpressure();
    bus_if.in_vec = 4'b1001;
    bus_if.in_valid = 1'b1;
    bus_if.out_ready = 1'b0;
    tick();
    bus_if.in_vec = 4'b0010;
    for (int c = 0; c < 3; c++) begin
      n_checks++; if ({bus_if.out_valid, bus_if.out_last, bus_if.in_ready} !== 3'b100 || bus_if.out_idx !== 2'd0) begin
        n_fail++; $display("FAIL bp_hold[%0d]: got valid/last/rdy=%b idx=%0d expected 100 idx=0", c, {bus_if.out_valid, bus_if.out_last, bus_if.in_ready}, bus_if.out_idx);
      end
      tick();
    end
    bus_if.in_valid = 1'b0;
    bus_if.out_ready = 1'b1;
    n_checks++; if (bus_if.out_idx !== 2'd0 || bus_if.out_valid !== 1'b1) begin
      n_fail++; $display("FAIL bp_first: got idx=%0d valid=%b expected idx=0 valid=1", bus_if.out_idx, bus_if.out_valid);
    end
    tick();
    n_checks++; if (bus_if.out_idx !== 2'd3 || bus_if.out_last !== 1'b1 || bus_if.out_valid !== 1'b1) begin
      n_fail++; $display("FAIL bp_second: got idx=%0d last=%b valid=%b expected idx=3 last=1 valid=1", bus_if.out_idx, bus_if.out_last, bus_if.out_valid);
    end
    tick();
    n_checks++; if ({bus_if.out_valid, bus_if.busy, bus_if.in_ready} !== 3'b001) begin
      n_fail++; $display("FAIL bp_done: got %b expected 001", {bus_if.out_valid, bus_if.busy, bus_if.in_ready});
    end
  endtask

  task automatic test_zero();
    bus_if.in_vec = 4'b0000;
    bus_if.in_valid = 1'b1;
    tick();
    bus_if.in_valid = 1'b0;
    n_checks++; if ({bus_if.err_zero, bus_if.out_valid, bus_if.in_ready, bus_if.err_multi} !== 4'b1010) begin
      n_fail++; $display("FAIL zero_pulse: got %b expected 1010", {bus_if.err_zero, bus_if.out_valid, bus_if.in_ready, bus_if.err_multi});
    end
    tick();
    n_checks++; if ({bus_if.err_zero, bus_if.out_valid} !== 2'b00) begin
      n_fail++; $display("FAIL zero_clear: got %b expected 00", {bus_if.err_zero, bus_if.out_valid});
    end
  endtask

  task automatic test_strict();
    bus_if.in_vec = 4'b0110;
    bus_if.in_valid = 1'b1;
    tick();
    bus_if.in_valid = 1'b0;
    n_checks++; if ({bus_if.err_multi, bus_if.out_valid, bus_if.in_ready, bus_if.busy} !== 4'b1010) begin
      n_fail++; $display("FAIL strict_pulse: got %b expected 1010", {bus_if.err_multi, bus_if.out_valid, bus_if.in_ready, bus_if.busy});
    end
    tick();
    n_checks++; if ({bus_if.err_multi, bus_if.out_valid} !== 2'b00) begin
      n_fail++; $display("FAIL strict_clear: got %b expected 00", {bus_if.err_multi, bus_if.out_valid});
    end
  endtask

  task automatic test_back_to_back();
    bus_if.in_vec = 4'b0010;
    bus_if.in_valid = 1'b1;
    bus_if.out_ready = 1'b1;
    tick();
    bus_if.in_vec = 4'b1000;
    n_checks++; if (bus_if.out_idx !== 2'd1 || bus_if.out_last !== 1'b1) begin
      n_fail++; $display("FAIL b2b_first: got idx=%0d last=%b expected idx=1 last=1", bus_if.out_idx, bus_if.out_last);
    end
    tick();
    n_checks++; if ({bus_if.out_valid, bus_if.in_ready} !== 2'b01) begin
      n_fail++; $display("FAIL b2b_gap: got %b expected 01", {bus_if.out_valid, bus_if.in_ready});
    end
    tick();
    bus_if.in_valid = 1'b0;
    n_checks++; if (bus_if.out_valid !== 1'b1 || bus_if.out_idx !== 2'd3) begin
      n_fail++; $display("FAIL b2b_second: got valid=%b idx=%0d expected valid=1 idx=3", bus_if.out_valid, bus_if.out_idx);
    end
    tick();
  endtask

  task automatic test_reset_mid_emit();
    bus_if.in_vec = 4'b1111;
    bus_if.in_valid = 1'b1;
    bus_if.out_ready = 1'b1;
    tick();
    bus_if.in_valid = 1'b0;
    n_checks++; if (bus_if.out_idx !== 2'd0 || bus_if.out_valid !== 1'b1) begin
      n_fail++; $display("FAIL rmid_first: got idx=%0d valid=%b expected idx=0 valid=1", bus_if.out_idx, bus_if.out_valid);
    end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    n_checks++; if ({bus_if.out_valid, bus_if.busy} !== 2'b00) begin
      n_fail++; $display("FAIL rmid_reset: got %b expected 00", {bus_if.out_valid, bus_if.busy});
    end
    for (int c = 0; c < 4; c++) begin
      tick();
      n_checks++; if (bus_if.out_valid !== 1'b0) begin
        n_fail++; $display("FAIL rmid_quiet[%0d]: got valid=%b expected 0", c, bus_if.out_valid);
      end
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail = 0;
    test_reset();
    test_onehot();
    test_zero();
    test_back_to_back();
`ifdef ENC_ONEHOT_STRICT_EN
    test_strict();
`else
    test_multi_stream();
    test_backpressure();
    test_reset_mid_emit();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
